// File: rtl/m2v_block_seq_if.sv
// m2v_block_seq_if
//   Bundles the macroblock descriptor handshake, the flush request/ack pair,
//   the downstream block_ready input and the stage-3 side-info bus of the
//   block sequencer.
//
//   Handshake semantics: a descriptor transfers on a rising clk edge where
//   mb_valid and mb_ready are both 1; the producer holds mb_* stable while
//   mb_valid=1 and mb_ready=0. flush is a level held until flush_ack pulses.
//   blk_ready is sampled only while the sequencer is armed; block_start is a
//   one-cycle pulse during which s3_* are valid.
//
//   modport master : descriptor producer / downstream consumer (drives inputs)
//   modport slave  : the sequencer itself
interface m2v_block_seq_if #(
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
);
    logic                 mb_valid;
    logic                 mb_ready;
    logic [MBX_WIDTH-1:0] mb_x;
    logic [MBY_WIDTH-1:0] mb_y;
    logic                 mb_intra;
    logic [5:0]           mb_cbp;
    logic                 flush;
    logic                 flush_ack;
    logic                 blk_ready;
    logic [MBX_WIDTH-1:0] s3_mb_x;
    logic [MBY_WIDTH-1:0] s3_mb_y;
    logic                 s3_mb_intra;
    logic [2:0]           s3_block;
    logic                 s3_coded;
    logic                 s3_enable;
    logic                 block_start;

    modport master (
        output mb_valid, mb_x, mb_y, mb_intra, mb_cbp, flush, blk_ready,
        input  mb_ready, flush_ack, s3_mb_x, s3_mb_y, s3_mb_intra,
               s3_block, s3_coded, s3_enable, block_start
    );

    modport slave (
        input  mb_valid, mb_x, mb_y, mb_intra, mb_cbp, flush, blk_ready,
        output mb_ready, flush_ack, s3_mb_x, s3_mb_y, s3_mb_intra,
               s3_block, s3_coded, s3_enable, block_start
    );
endinterface

// File: rtl/m2v_block_seq.sv
// m2v_block_seq
//   Stage-3 side-information producer and block sequencer. Accepts one
//   macroblock descriptor, then walks its six 4:2:0 blocks (0..5), issuing one
//   block_start pulse per block with the matching s3_* side info. A flush
//   request issues a single bubble pulse (s3_enable=0) to drain stage 4.
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : synchronous active-low reset
//   bus        : m2v_block_seq_if.slave (descriptor, flush, side-info bus)
//   dbg_state  : current FSM state (0=IDLE, 1=ARM, 2=PULSE)
module m2v_block_seq #(
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    m2v_block_seq_if.slave        bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_PULSE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           blk_cnt_q, blk_cnt_d;
    logic [5:0]           cbp_q, cbp_d;
    logic                 flush_flag_q, flush_flag_d;
    logic [MBX_WIDTH-1:0] s3_mb_x_q, s3_mb_x_d;
    logic [MBY_WIDTH-1:0] s3_mb_y_q, s3_mb_y_d;
    logic                 s3_mb_intra_q, s3_mb_intra_d;
    logic [2:0]           s3_block_q, s3_block_d;
    logic                 s3_coded_q, s3_coded_d;
    logic                 s3_enable_q, s3_enable_d;
    logic                 block_start_q, block_start_d;
    logic                 flush_ack_q, flush_ack_d;
    logic [2:0]           blk_nxt;

    assign blk_nxt = blk_cnt_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        blk_cnt_d     = blk_cnt_q;
        cbp_d         = cbp_q;
        flush_flag_d  = flush_flag_q;
        s3_mb_x_d     = s3_mb_x_q;
        s3_mb_y_d     = s3_mb_y_q;
        s3_mb_intra_d = s3_mb_intra_q;
        s3_block_d    = s3_block_q;
        s3_coded_d    = s3_coded_q;
        s3_enable_d   = s3_enable_q;
        block_start_d = 1'b0;
        flush_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A descriptor wins over a pending flush; the flush is then
                // served once the macroblock has drained.
                if (bus.mb_valid) begin
                    cbp_d         = bus.mb_cbp;
                    blk_cnt_d     = 3'd0;
                    s3_mb_x_d     = bus.mb_x;
                    s3_mb_y_d     = bus.mb_y;
                    s3_mb_intra_d = bus.mb_intra;
                    s3_block_d    = 3'd0;
                    s3_coded_d    = bus.mb_intra | bus.mb_cbp[5];
                    s3_enable_d   = 1'b1;
                    state_d       = S_ARM;
                end else if (bus.flush) begin
                    // Bubble keeps the last macroblock position on the bus.
                    flush_ack_d  = 1'b1;
                    flush_flag_d = 1'b1;
                    blk_cnt_d    = 3'd0;
                    s3_block_d   = 3'd0;
                    s3_coded_d   = 1'b0;
                    s3_enable_d  = 1'b0;
                    state_d      = S_ARM;
                end
            end
            S_ARM: begin
                if (bus.blk_ready) begin
                    block_start_d = 1'b1;
                    state_d       = S_PULSE;
                end
            end
            S_PULSE: begin
                if (flush_flag_q || blk_cnt_q == 3'd5) begin
                    flush_flag_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    blk_cnt_d  = blk_nxt;
                    s3_block_d = blk_nxt;
                    // cbp bit 5 belongs to block 0, so the bit index runs downward.
                    s3_coded_d = s3_mb_intra_q | cbp_q[3'd5 - blk_nxt];
                    state_d    = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            blk_cnt_q     <= 3'd0;
            cbp_q         <= 6'd0;
            flush_flag_q  <= 1'b0;
            s3_mb_x_q     <= '0;
            s3_mb_y_q     <= '0;
            s3_mb_intra_q <= 1'b0;
            s3_block_q    <= 3'd0;
            s3_coded_q    <= 1'b0;
            s3_enable_q   <= 1'b0;
            block_start_q <= 1'b0;
            flush_ack_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
            cbp_q         <= cbp_d;
            flush_flag_q  <= flush_flag_d;
            s3_mb_x_q     <= s3_mb_x_d;
            s3_mb_y_q     <= s3_mb_y_d;
            s3_mb_intra_q <= s3_mb_intra_d;
            s3_block_q    <= s3_block_d;
            s3_coded_q    <= s3_coded_d;
            s3_enable_q   <= s3_enable_d;
            block_start_q <= block_start_d;
            flush_ack_q   <= flush_ack_d;
        end
    end

    // mb_ready is the only combinational output: it must drop during reset.
    assign bus.mb_ready    = reset_n & (state_q == S_IDLE);
    assign bus.flush_ack   = flush_ack_q;
    assign bus.s3_mb_x     = s3_mb_x_q;
    assign bus.s3_mb_y     = s3_mb_y_q;
    assign bus.s3_mb_intra = s3_mb_intra_q;
    assign bus.s3_block    = s3_block_q;
    assign bus.s3_coded    = s3_coded_q;
    assign bus.s3_enable   = s3_enable_q;
    assign bus.block_start = block_start_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_m2v_block_seq.sv
module tb_m2v_block_seq;

    localparam int MBX_WIDTH = 6;
    localparam int MBY_WIDTH = 5;
    localparam int W = MBX_WIDTH + MBY_WIDTH + 6;

    logic       clk;
    logic       reset_n;
    logic [1:0] dbg_state;

    m2v_block_seq_if #(.MBX_WIDTH(MBX_WIDTH), .MBY_WIDTH(MBY_WIDTH)) bus ();

    m2v_block_seq #(.MBX_WIDTH(MBX_WIDTH), .MBY_WIDTH(MBY_WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = 0;
    bit gap_mode = 1'b0;
    bit rand_ready = 1'b0;
    logic blk_ready_dir = 1'b0;
    logic [W-1:0] prev_vec = '0;
    logic prev_ready = 1'b0;
    logic [W-1:0] cur_vec;
    logic [W-1:0] exp_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] pack(input logic [MBX_WIDTH-1:0] x,
                                          input logic [MBY_WIDTH-1:0] y,
                                          input logic intra, input logic [2:0] blk,
                                          input logic coded, input logic en);
        return {x, y, intra, blk, coded, en};
    endfunction

    assign cur_vec = {bus.s3_mb_x, bus.s3_mb_y, bus.s3_mb_intra,
                      bus.s3_block, bus.s3_coded, bus.s3_enable};

    // Pulse monitor: every block_start must match the next expected block,
    // follow a cycle with blk_ready=1, and carry the side info already shown
    // in the preceding (armed) cycle.
    always @(negedge clk) begin
        if (bus.block_start === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("pulse_sideinfo", 32'(cur_vec), 32'(exp_e));
            end
            check("pulse_side_stable", 32'(cur_vec), 32'(prev_vec));
            check("pulse_after_ready", 32'(prev_ready), 32'd1);
            check("pulse_state", 32'(dbg_state), 32'd2);
            if (gap_mode && bus.s3_block != 3'd0)
                check("pulse_gap", 32'(cyc - last_pulse_cyc), 32'd2);
            last_pulse_cyc = cyc;
        end
        prev_vec   = cur_vec;
        prev_ready = bus.blk_ready;
    end

    // blk_ready driver: directed level or random toggling
    initial begin
        bus.blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.blk_ready = 1'($urandom_range(0, 1));
            else            bus.blk_ready = blk_ready_dir;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queues the first nblk expected blocks, then offers the descriptor until
    // accepted. coded_seq is hand-computed: bit 5 = block 0 ... bit 0 = block 5.
    task automatic send_mb(input logic [MBX_WIDTH-1:0] x, input logic [MBY_WIDTH-1:0] y,
                           input logic intra, input logic [5:0] cbp,
                           input logic [5:0] coded_seq, input int nblk);
        bit ok = 1'b0;
        for (int b = 0; b < nblk; b++)
            exp_q.push_back(pack(x, y, intra, 3'(b), coded_seq[5-b], 1'b1));
        bus.mb_valid = 1'b1;
        bus.mb_x     = x;
        bus.mb_y     = y;
        bus.mb_intra = intra;
        bus.mb_cbp   = cbp;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mb_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("mb_accept_timeout", 32'd0, 32'd1);
        tick();
        bus.mb_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (pulse_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(tag, 32'(pulse_cnt), 32'(target));
    endtask

    // ---------------- main sequence ----------------
    int base;
    bit got_ack;

    initial begin
        reset_n      = 1'b0;
        bus.mb_valid = 1'b0;
        bus.mb_x     = '0;
        bus.mb_y     = '0;
        bus.mb_intra = 1'b0;
        bus.mb_cbp   = '0;
        bus.flush    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mb_ready", 32'(bus.mb_ready), 32'd0);
        check("rst_block_start", 32'(bus.block_start), 32'd0);
        check("rst_flush_ack", 32'(bus.flush_ack), 32'd0);
        check("rst_side_info", 32'(cur_vec), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        tick();
        reset_n = 1'b1;
        blk_ready_dir = 1'b1;

        // Idle with blk_ready=1: ready immediately, no pulses
        @(negedge clk);
        check("idle_mb_ready", 32'(bus.mb_ready), 32'd1);
        repeat (5) tick();
        check("idle_no_pulse", 32'(pulse_cnt), 32'd0);

        // Intra MB x=3 y=2 cbp=0: all coded, back-to-back 2-cycle spacing
        gap_mode = 1'b1;
        send_mb(6'd3, 5'd2, 1'b1, 6'b000000, 6'b111111, 6);
        @(negedge clk);
        check("busy_mb_ready", 32'(bus.mb_ready), 32'd0);
        wait_pulses(6, "intra_pulse_timeout");
        @(negedge clk);
        check("intra_done_mb_ready", 32'(bus.mb_ready), 32'd1);
        gap_mode = 1'b0;
        tick();

        // Non-intra MB cbp=101001 -> coded 1,0,1,0,0,1
        send_mb(6'd10, 5'd7, 1'b0, 6'b101001, 6'b101001, 6);
        wait_pulses(12, "cbp_pulse_timeout");
        tick();

        // Random blk_ready: cbp=010110 -> coded 0,1,0,1,1,0
        rand_ready = 1'b1;
        send_mb(6'd63, 5'd31, 1'b0, 6'b010110, 6'b010110, 6);
        wait_pulses(18, "rand_pulse_timeout");
        rand_ready = 1'b0;
        repeat (2) tick();
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // mb_valid and flush together: MB first, then ack and one bubble
        base = pulse_cnt;
        bus.flush = 1'b1;
        send_mb(6'd5, 5'd9, 1'b0, 6'b000000, 6'b000000, 6);
        exp_q.push_back(pack(6'd5, 5'd9, 1'b0, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        check("no_ack_with_mb", 32'(bus.flush_ack), 32'd0);
        got_ack = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.flush_ack) begin
                got_ack = 1'b1;
                break;
            end
        end
        check("flush_ack_seen", 32'(got_ack), 32'd1);
        check("ack_after_mb", 32'(pulse_cnt - base), 32'd6);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_ack_one_cycle", 32'(bus.flush_ack), 32'd0);
        wait_pulses(base + 7, "flush_pulse_timeout");
        repeat (3) tick();
        check("flush_single_bubble", 32'(pulse_cnt - base), 32'd7);
        @(negedge clk);
        check("flush_back_idle", 32'(bus.mb_ready), 32'd1);
        tick();

        // Reset for one cycle after the 3rd pulse of a macroblock
        base = pulse_cnt;
        send_mb(6'd1, 5'd1, 1'b1, 6'b111111, 6'b111111, 3);
        wait_pulses(base + 3, "pre_reset_timeout");
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_mb_ready", 32'(bus.mb_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_side_info", 32'(cur_vec), 32'd0);
        check("post_rst_block_start", 32'(bus.block_start), 32'd0);
        check("post_rst_mb_ready", 32'(bus.mb_ready), 32'd1);
        repeat (6) tick();
        check("post_rst_no_pulse", 32'(pulse_cnt - base), 32'd3);

        // New MB after reset starts at block 0: cbp=100000 -> coded 1,0,0,0,0,0
        send_mb(6'd2, 5'd3, 1'b0, 6'b100000, 6'b100000, 6);
        wait_pulses(base + 9, "post_rst_mb_timeout");
        repeat (3) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_pulse_total", 32'(pulse_cnt), 32'(base + 9));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
